// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Function : Interrupt collector in front of proc. Captures keypad events
//            into a single holding register and Ethernet words into a small
//            FIFO, then presents one interrupt at a time (key first) with its
//            payload until the core acknowledges it. A one-cycle gap state
//            separates back-to-back interrupts.
// Options  : IRQ_KEY_SYNC_EN - treat key_event as an asynchronous level and
//            pass it through a 2-flop synchronizer plus rising-edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ETH_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_event,
  input  logic [DATA_W-1:0] key_data,
  input  logic              eth_valid,
  input  logic [DATA_W-1:0] eth_data,
  output logic              eth_ready,
  input  logic              irq_ack,
  output logic              interrupt_key,
  output logic              interrupt_eth,
  output logic [DATA_W-1:0] interrupt_source_data,
  output logic              key_overrun
);

  localparam int          AW      = $clog2(ETH_DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(ETH_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_ETH  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t            r_state;
  logic              w_key_evt;
  logic              w_key_ack;
  logic              r_key_pend;
  logic [DATA_W-1:0] r_key_reg;

  logic [DATA_W-1:0] r_mem [ETH_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [AW:0]       w_count;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;

`ifdef IRQ_KEY_SYNC_EN
  logic r_key_sync1;
  logic r_key_sync2;
  logic r_key_prev;
  logic r_key_rise;

  // Synchronize the asynchronous key level and register a one-cycle rise pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_sync1 <= 1'b0;
      r_key_sync2 <= 1'b0;
      r_key_prev  <= 1'b0;
      r_key_rise  <= 1'b0;
    end else begin
      r_key_sync1 <= key_event;
      r_key_sync2 <= r_key_sync1;
      r_key_prev  <= r_key_sync2;
      r_key_rise  <= r_key_sync2 & ~r_key_prev;
    end
  end

  assign w_key_evt = r_key_rise;
`else
  assign w_key_evt = key_event;
`endif

  // FIFO occupancy comes from the pointer difference; the wrap bit
  // distinguishes full from empty when the index bits match.
  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign eth_ready    = (w_count < C_DEPTH);
  assign w_push       = eth_valid && eth_ready;
  assign w_pop        = (r_state == ST_ETH) && irq_ack;
  assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
  assign w_key_ack    = (r_state == ST_KEY) && irq_ack;

  // FIFO storage; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= eth_data;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Key holding register; an event arriving with the ack replaces the old key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_pend  <= 1'b0;
      r_key_reg   <= '0;
      key_overrun <= 1'b0;
    end else begin
      if (w_key_evt) begin
        if (!r_key_pend || w_key_ack) begin
          r_key_pend <= 1'b1;
          r_key_reg  <= key_data;
        end else begin
          key_overrun <= 1'b1;
        end
      end else if (w_key_ack) begin
        r_key_pend <= 1'b0;
      end
    end
  end

  // Presentation FSM with registered interrupt lines and payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state               <= ST_IDLE;
      interrupt_key         <= 1'b0;
      interrupt_eth         <= 1'b0;
      interrupt_source_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_key_pend) begin
            r_state               <= ST_KEY;
            interrupt_key         <= 1'b1;
            interrupt_source_data <= r_key_reg;
          end else if (!w_fifo_empty) begin
            r_state               <= ST_ETH;
            interrupt_eth         <= 1'b1;
            interrupt_source_data <= w_head;
          end
        end
        ST_KEY: begin
          if (irq_ack) begin
            r_state               <= ST_GAP;
            interrupt_key         <= 1'b0;
            interrupt_source_data <= '0;
          end
        end
        ST_ETH: begin
          if (irq_ack) begin
            r_state               <= ST_GAP;
            interrupt_eth         <= 1'b0;
            interrupt_source_data <= '0;
          end
        end
        default: begin
          r_state               <= ST_IDLE;
          interrupt_key         <= 1'b0;
          interrupt_eth         <= 1'b0;
          interrupt_source_data <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt collector sitting directly upstream of `proc`. It captures keypad events and Ethernet receive words, buffers them, and presents them one at a time to the core on `interrupt_key` / `interrupt_eth` with the 32-bit payload on `interrupt_source_data`. Each interrupt is held until the core acknowledges it. The block also provides Ethernet backpressure and a sticky overrun flag for dropped key events.

## Interface
Parameters:
- `DATA_W`, 32: payload width. Must match the `proc` `interrupt_source_data` width.
- `ETH_DEPTH`, 4: Ethernet FIFO entries. Must be a power of 2 and ≥2.

Ports:
- `clk`  in  1  the single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_event`  in  1  keypad event. It is a one-cycle pulse, or a level when `IRQ_KEY_SYNC_EN` is defined.
- `key_data`  in  DATA_W  key code, sampled with the event.
- `eth_valid`  in  1  Ethernet word offered.
- `eth_data`  in  DATA_W  Ethernet word.
- `eth_ready`  out  1  FIFO can accept a word.
- `irq_ack`  in  1  core acknowledges the currently presented interrupt.
- `interrupt_key`  out  1  key interrupt presented; goes to `proc.interrupt_key`.
- `interrupt_eth`  out  1  Ethernet interrupt presented; goes to `proc.interrupt_eth`.
- `interrupt_source_data`  out  DATA_W  payload of the presented interrupt; goes to `proc.interrupt_source_data`.
- `key_overrun`  out  1  sticky flag: a key event was dropped.

## Operation
Storage:
- Key holding register: `key_pend` plus `key_reg`.
- Ethernet FIFO: `ETH_DEPTH` entries, read/write pointers with an extra wrap bit, count derived from the pointers.

Capture:
- A key event (after the optional synchronizer) with `key_pend`=0 sets `key_pend` and loads `key_reg`.
- A key event with `key_pend`=1 is dropped and sets `key_overrun`, except in the case below.
- An Ethernet push happens when `eth_valid && eth_ready`.
- `eth_ready` = (count < `ETH_DEPTH`). It is combinational from registered state, with no dependence on `irq_ack`. When the FIFO is full, `eth_ready`=0 even if a pop happens in the same cycle.

FSM states: IDLE, KEY, ETH, GAP.
- IDLE → KEY if `key_pend`. Otherwise IDLE → ETH if the FIFO is not empty. Key has fixed priority over Ethernet.
- KEY → GAP on `irq_ack`. At that edge `key_pend` is cleared.
- ETH → GAP on `irq_ack`. At that edge the FIFO head is popped.
- GAP → IDLE unconditionally, after one cycle. This guarantees the core sees a low level between back-to-back interrupts.
- `irq_ack` in IDLE or GAP is ignored.

Outputs are a Moore decode of the state:
- `interrupt_key` = (state==KEY).
- `interrupt_eth` = (state==ETH).
- `interrupt_source_data` = `key_reg` in KEY, FIFO head in ETH, 0 otherwise.
- The payload is stable for the whole time an interrupt line is high.

Boundary conditions:
- Key event on the same edge the key is acked: `key_pend` stays 1 and `key_reg` is reloaded with the new data. No overrun is flagged.
- Ethernet push and pop on the same edge: count is unchanged. Pointer wrap is handled by the wrap bit.
- `key_overrun` clears only on reset.
- Reset asserted mid-handshake: all state is abandoned immediately. The FIFO is emptied, `key_pend`=0 and state=IDLE.

## Timing
Reset values:
- `interrupt_key`=0, `interrupt_eth`=0, `interrupt_source_data`=0.
- `key_overrun`=0.
- `eth_ready`=1.

Latency:
- Event sampled at edge N (key capture or Ethernet push) → interrupt line high after edge N+1, if the FSM is in IDLE.
- `irq_ack` sampled high at edge M → line low after edge M; the next interrupt can rise after edge M+2 at the earliest.
- Ethernet throughput: at most 1 word per 3 cycles under continuous immediate ack.

## Configuration
Macro: `IRQ_KEY_SYNC_EN`.
- Defined: `key_event` is treated as an asynchronous level. It passes through a 2-flop synchronizer and a rising-edge detector, and `key_data` is sampled on the detected edge. This adds 3 cycles of key latency; a held level produces exactly one event.
- Undefined: `key_event` is a synchronous one-cycle pulse used directly, and a held level produces an event every cycle.

## Test plan
- Reset with `rst_n`=0 mid-cycle → all outputs at their reset values, `eth_ready`=1. Key events (pulse) are used in the remaining scenarios.
- Key pulse `key_data`=0x00000005 → `interrupt_key`=1 with payload 0x5 two edges later. Hold `irq_ack` off for 10 cycles → line and payload stay stable. Ack → line low, GAP cycle, IDLE.
- Push 0xA1, 0xA2, 0xA3, 0xA4 → `eth_ready`=0 after the 4th push. Offer a 5th word → not accepted. Ack each immediately → `interrupt_eth` payloads 0xA1..0xA4 in order, each separated by one low cycle.
- Key pulse and Ethernet push on the same edge (Ethernet 0xB0, key 0x7) → KEY presented first with 0x7, then ETH with 0xB0.
- Two key pulses (0x1 then 0x2) with no ack → `key_overrun`=1 and payload stays 0x1. Pulse 0x3 on the same edge as the ack → the next KEY payload is 0x3.
- With `IRQ_KEY_SYNC_EN`, hold `key_event` high for 20 cycles → exactly one key interrupt, rising 3 cycles later than the pulse build.
